// File: rtl/jtag_pkg.sv
// Shared JTAG TAP types and constants: state encoding, instruction opcodes
// and the fixed IR capture pattern.
package jtag_pkg;

    localparam int IR_LEN = 4;

    // 16 TAP controller states, 4-bit encoding
    typedef enum logic [3:0] {
        TLR   = 4'd0,
        RTI   = 4'd1,
        SelDR = 4'd2,
        CapDR = 4'd3,
        ShDR  = 4'd4,
        Ex1DR = 4'd5,
        PaDR  = 4'd6,
        Ex2DR = 4'd7,
        UpdDR = 4'd8,
        SelIR = 4'd9,
        CapIR = 4'd10,
        ShIR  = 4'd11,
        Ex1IR = 4'd12,
        PaIR  = 4'd13,
        Ex2IR = 4'd14,
        UpdIR = 4'd15
    } tap_state_t;

    // Instruction opcodes; any code not listed here behaves as BYPASS
    localparam logic [IR_LEN-1:0] OP_EXTEST         = 4'b0000;
    localparam logic [IR_LEN-1:0] OP_SAMPLE_PRELOAD = 4'b0001;
    localparam logic [IR_LEN-1:0] OP_IDCODE         = 4'b0010;
    localparam logic [IR_LEN-1:0] OP_DEBUG          = 4'b1000;
    localparam logic [IR_LEN-1:0] OP_MBIST          = 4'b1001;
    localparam logic [IR_LEN-1:0] OP_BYPASS         = 4'b1111;

    // Pattern loaded into the IR shifter in Capture-IR (LSB pair 01)
    localparam logic [IR_LEN-1:0] IR_CAPTURE = 4'b0101;

endpackage

// File: rtl/jtag_tap_fsm.sv
// TAP controller state machine: state register, TMS-driven next-state logic
// and Moore strobes decoded from the current state.
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic tclk,
    input  logic test_logic_reset_i,
    input  logic tms_i,
    output logic test_logic_reset_o,
    output logic capture_dr_o,
    output logic shift_dr_o,
    output logic pause_dr_o,
    output logic update_dr_o,
    output logic capture_ir_o,
    output logic shift_ir_o,
    output logic update_ir_o
);

    tap_state_t state;
    tap_state_t state_next;

    // State register; external reset lands in Test-Logic-Reset on this edge
    always_ff @(posedge tclk) begin
        if (test_logic_reset_i) begin
            state <= TLR;
        end else begin
            state <= state_next;
        end
    end

    // Standard 1149.1 TMS graph plus strobes decoded from the current state
    always_comb begin
        state_next         = state;
        test_logic_reset_o = 1'b0;
        capture_dr_o       = 1'b0;
        shift_dr_o         = 1'b0;
        pause_dr_o         = 1'b0;
        update_dr_o        = 1'b0;
        capture_ir_o       = 1'b0;
        shift_ir_o         = 1'b0;
        update_ir_o        = 1'b0;
        case (state)
            TLR: begin
                test_logic_reset_o = 1'b1;
                state_next = tms_i ? TLR : RTI;
            end
            RTI:   state_next = tms_i ? SelDR : RTI;
            SelDR: state_next = tms_i ? SelIR : CapDR;
            CapDR: begin
                capture_dr_o = 1'b1;
                state_next = tms_i ? Ex1DR : ShDR;
            end
            ShDR: begin
                shift_dr_o = 1'b1;
                state_next = tms_i ? Ex1DR : ShDR;
            end
            Ex1DR: state_next = tms_i ? UpdDR : PaDR;
            PaDR: begin
                pause_dr_o = 1'b1;
                state_next = tms_i ? Ex2DR : PaDR;
            end
            Ex2DR: state_next = tms_i ? UpdDR : ShDR;
            UpdDR: begin
                update_dr_o = 1'b1;
                state_next = tms_i ? SelDR : RTI;
            end
            SelIR: state_next = tms_i ? TLR : CapIR;
            CapIR: begin
                capture_ir_o = 1'b1;
                state_next = tms_i ? Ex1IR : ShIR;
            end
            ShIR: begin
                shift_ir_o = 1'b1;
                state_next = tms_i ? Ex1IR : ShIR;
            end
            Ex1IR: state_next = tms_i ? UpdIR : PaIR;
            PaIR:  state_next = tms_i ? Ex2IR : PaIR;
            Ex2IR: state_next = tms_i ? UpdIR : ShIR;
            UpdIR: begin
                update_ir_o = 1'b1;
                state_next = tms_i ? SelDR : RTI;
            end
            default: state_next = TLR;
        endcase
    end

endmodule

// File: rtl/jtag_tap_ctrl.sv
// JTAG TAP controller top: instruction register, bypass and IDCODE data
// registers, instruction decode and the negedge-registered TDO mux.
module jtag_tap_ctrl #(
    parameter int          IR_LEN     = 4,
    // Bit 0 must be 1 so IDCODE is distinguishable from BYPASS on a scan
    parameter logic [31:0] IDCODE_VAL = 32'h1000_0001
) (
    input  logic tclk,
    input  logic test_logic_reset_i,
    input  logic tms_i,
    input  logic tdi_i,
    output logic tdo_o,
    output logic tdo_oe_o,
    output logic test_logic_reset_o,
    output logic capture_dr_o,
    output logic shift_dr_o,
    output logic pause_dr_o,
    output logic update_dr_o,
    output logic extest_sel_o,
    output logic sample_preload_sel_o,
    output logic debug_sel_o,
    output logic mbist_sel_o,
    input  logic bs_chain_tdi_i,
    input  logic debug_tdi_i,
    input  logic mbist_tdi_i
);
    import jtag_pkg::*;

    logic              capture_ir;
    logic              shift_ir;
    logic              update_ir;
    logic [IR_LEN-1:0] ir;
    logic [IR_LEN-1:0] ir_shift;
    logic              bypass_bit;
    logic [31:0]       idcode_shift;
    logic              idcode_sel;
    logic              tdo_src;

    jtag_tap_fsm u_fsm (
        .tclk               (tclk),
        .test_logic_reset_i (test_logic_reset_i),
        .tms_i              (tms_i),
        .test_logic_reset_o (test_logic_reset_o),
        .capture_dr_o       (capture_dr_o),
        .shift_dr_o         (shift_dr_o),
        .pause_dr_o         (pause_dr_o),
        .update_dr_o        (update_dr_o),
        .capture_ir_o       (capture_ir),
        .shift_ir_o         (shift_ir),
        .update_ir_o        (update_ir)
    );

    // IR shifter: capture fixed pattern, shift right with TDI entering the MSB
    always_ff @(posedge tclk) begin
        if (test_logic_reset_i || capture_ir) begin
            ir_shift <= IR_CAPTURE;
        end else if (shift_ir) begin
            ir_shift <= {tdi_i, ir_shift[IR_LEN-1:1]};
        end
    end

    // Active IR: IDCODE while in Test-Logic-Reset, new opcode on leaving UpdIR
    always_ff @(posedge tclk) begin
        if (test_logic_reset_i || test_logic_reset_o) begin
            ir <= OP_IDCODE;
        end else if (update_ir) begin
            ir <= ir_shift;
        end
    end

    // Bypass bit: captures 0, then one-stage delay of TDI while shifting
    always_ff @(posedge tclk) begin
        if (test_logic_reset_i || capture_dr_o) begin
            bypass_bit <= 1'b0;
        end else if (shift_dr_o) begin
            bypass_bit <= tdi_i;
        end
    end

    // IDCODE shifter: capture the device ID, shift right LSB-first
    always_ff @(posedge tclk) begin
        if (test_logic_reset_i || capture_dr_o) begin
            idcode_shift <= IDCODE_VAL;
        end else if (shift_dr_o) begin
            idcode_shift <= {tdi_i, idcode_shift[31:1]};
        end
    end

    // Instruction decode; selects forced low in Test-Logic-Reset because the
    // IR only returns to IDCODE on the first posedge spent there
    always_comb begin
        extest_sel_o         = 1'b0;
        sample_preload_sel_o = 1'b0;
        debug_sel_o          = 1'b0;
        mbist_sel_o          = 1'b0;
        idcode_sel           = 1'b0;
        if (!test_logic_reset_o) begin
            case (ir)
                OP_EXTEST:         extest_sel_o         = 1'b1;
                OP_SAMPLE_PRELOAD: sample_preload_sel_o = 1'b1;
                OP_IDCODE:         idcode_sel           = 1'b1;
                OP_DEBUG:          debug_sel_o          = 1'b1;
                OP_MBIST:          mbist_sel_o          = 1'b1;
                default:           ;
            endcase
        end
    end

    // TDO source selection from posedge-side state; zero when not shifting
    always_comb begin
        tdo_src = 1'b0;
        if (shift_ir) begin
            tdo_src = ir_shift[0];
        end else if (shift_dr_o) begin
            if (extest_sel_o || sample_preload_sel_o) begin
                tdo_src = bs_chain_tdi_i;
            end else if (debug_sel_o) begin
                tdo_src = debug_tdi_i;
            end else if (mbist_sel_o) begin
                tdo_src = mbist_tdi_i;
            end else if (idcode_sel) begin
                tdo_src = idcode_shift[0];
            end else begin
                tdo_src = bypass_bit;
            end
        end
    end

    // TDO and its enable change on the falling edge so the pad is stable
    // around the next rising edge of the downstream device
    always_ff @(negedge tclk) begin
        if (test_logic_reset_i) begin
            tdo_o    <= 1'b0;
            tdo_oe_o <= 1'b0;
        end else begin
            tdo_o    <= tdo_src;
            tdo_oe_o <= shift_ir | shift_dr_o;
        end
    end

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Self-checking bench for jtag_tap_ctrl: a string-keyed TAP model checked on
// every negedge, plus directed scans with literal expected TDO streams.
module tb_jtag_tap_ctrl;

    localparam logic [31:0] IDV = 32'h1000_0001;

    logic tclk = 1'b0;
    logic test_logic_reset_i, tms_i, tdi_i;
    logic tdo_o, tdo_oe_o, test_logic_reset_o;
    logic capture_dr_o, shift_dr_o, pause_dr_o, update_dr_o;
    logic extest_sel_o, sample_preload_sel_o, debug_sel_o, mbist_sel_o;
    logic bs_chain_tdi_i, debug_tdi_i, mbist_tdi_i;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;
    logic last_tdo;
    bit [31:0] bs_pat, dbg_pat, mb_pat;

    jtag_tap_ctrl #(.IR_LEN(4), .IDCODE_VAL(IDV)) dut (
        .tclk                 (tclk),
        .test_logic_reset_i   (test_logic_reset_i),
        .tms_i                (tms_i),
        .tdi_i                (tdi_i),
        .tdo_o                (tdo_o),
        .tdo_oe_o             (tdo_oe_o),
        .test_logic_reset_o   (test_logic_reset_o),
        .capture_dr_o         (capture_dr_o),
        .shift_dr_o           (shift_dr_o),
        .pause_dr_o           (pause_dr_o),
        .update_dr_o          (update_dr_o),
        .extest_sel_o         (extest_sel_o),
        .sample_preload_sel_o (sample_preload_sel_o),
        .debug_sel_o          (debug_sel_o),
        .mbist_sel_o          (mbist_sel_o),
        .bs_chain_tdi_i       (bs_chain_tdi_i),
        .debug_tdi_i          (debug_tdi_i),
        .mbist_tdi_i          (mbist_tdi_i)
    );

    always #5 tclk = ~tclk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    string nx0 [string];
    string nx1 [string];
    string m_state = "TLR";
    bit [3:0]  m_ir = 4'b0010;
    bit [3:0]  m_irsh = 4'b0101;
    bit        m_byp = 1'b0;
    bit [31:0] m_id = IDV;
    bit        m_tdo = 1'b0;
    bit        m_oe = 1'b0;

    initial begin
        nx0["TLR"]="RTI";     nx1["TLR"]="TLR";
        nx0["RTI"]="RTI";     nx1["RTI"]="SelDR";
        nx0["SelDR"]="CapDR"; nx1["SelDR"]="SelIR";
        nx0["CapDR"]="ShDR";  nx1["CapDR"]="Ex1DR";
        nx0["ShDR"]="ShDR";   nx1["ShDR"]="Ex1DR";
        nx0["Ex1DR"]="PaDR";  nx1["Ex1DR"]="UpdDR";
        nx0["PaDR"]="PaDR";   nx1["PaDR"]="Ex2DR";
        nx0["Ex2DR"]="ShDR";  nx1["Ex2DR"]="UpdDR";
        nx0["UpdDR"]="RTI";   nx1["UpdDR"]="SelDR";
        nx0["SelIR"]="CapIR"; nx1["SelIR"]="TLR";
        nx0["CapIR"]="ShIR";  nx1["CapIR"]="Ex1IR";
        nx0["ShIR"]="ShIR";   nx1["ShIR"]="Ex1IR";
        nx0["Ex1IR"]="PaIR";  nx1["Ex1IR"]="UpdIR";
        nx0["PaIR"]="PaIR";   nx1["PaIR"]="Ex2IR";
        nx0["Ex2IR"]="ShIR";  nx1["Ex2IR"]="UpdIR";
        nx0["UpdIR"]="RTI";   nx1["UpdIR"]="SelDR";
    end

    // 0 EXTEST, 1 SAMPLE_PRELOAD, 2 IDCODE, 3 DEBUG, 4 MBIST, 5 BYPASS-like
    function automatic int kind(input bit [3:0] c);
        case (c)
            4'b0000: return 0;
            4'b0001: return 1;
            4'b0010: return 2;
            4'b1000: return 3;
            4'b1001: return 4;
            default: return 5;
        endcase
    endfunction

    always @(posedge tclk) begin
        string s;
        s = m_state;
        if (test_logic_reset_i) begin
            m_state = "TLR"; m_ir = 4'b0010; m_irsh = 4'b0101; m_byp = 1'b0; m_id = IDV;
        end else begin
            if (s == "CapIR") m_irsh = 4'b0101;
            if (s == "ShIR")  m_irsh = {tdi_i, m_irsh[3:1]};
            if (s == "UpdIR") m_ir = m_irsh;
            if (s == "TLR")   m_ir = 4'b0010;
            if (s == "CapDR") begin m_byp = 1'b0; m_id = IDV; end
            if (s == "ShDR")  begin m_byp = tdi_i; m_id = {tdi_i, m_id[31:1]}; end
            m_state = tms_i ? nx1[s] : nx0[s];
        end
    end

    always @(negedge tclk) begin
        if (test_logic_reset_i) begin
            m_tdo = 1'b0; m_oe = 1'b0;
        end else begin
            m_oe  = (m_state == "ShIR") || (m_state == "ShDR");
            m_tdo = 1'b0;
            if (m_state == "ShIR") m_tdo = m_irsh[0];
            else if (m_state == "ShDR") begin
                case (kind(m_ir))
                    0, 1:    m_tdo = bs_chain_tdi_i;
                    2:       m_tdo = m_id[0];
                    3:       m_tdo = debug_tdi_i;
                    4:       m_tdo = mbist_tdi_i;
                    default: m_tdo = m_byp;
                endcase
            end
        end
    end

    // Compare every DUT output against the model once per cycle
    always @(negedge tclk) begin
        bit act_tlr;
        #1;
        if (chk_en) begin
            act_tlr = (m_state == "TLR");
            chk("tlr_o",    test_logic_reset_o, act_tlr);
            chk("cap_dr",   capture_dr_o, m_state == "CapDR");
            chk("sh_dr",    shift_dr_o,   m_state == "ShDR");
            chk("pa_dr",    pause_dr_o,   m_state == "PaDR");
            chk("upd_dr",   update_dr_o,  m_state == "UpdDR");
            chk("sel_ext",  extest_sel_o,         !act_tlr && kind(m_ir) == 0);
            chk("sel_sp",   sample_preload_sel_o, !act_tlr && kind(m_ir) == 1);
            chk("sel_dbg",  debug_sel_o,          !act_tlr && kind(m_ir) == 3);
            chk("sel_mb",   mbist_sel_o,          !act_tlr && kind(m_ir) == 4);
            chk("tdo",      tdo_o,    m_tdo);
            chk("tdo_oe",   tdo_oe_o, m_oe);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step(input bit tms, input bit tdi);
        tms_i = tms;
        tdi_i = tdi;
        @(negedge tclk);
        #1 last_tdo = tdo_o;
        @(posedge tclk);
        #2;
    endtask

    // From RTI: scan an opcode into the IR, return captured TDO bits, end in RTI
    task automatic load_ir(input bit [3:0] code, output bit [3:0] cap);
        step(1, 0); step(1, 0); step(0, 0); step(0, 0);
        for (int i = 0; i < 4; i++) begin
            step(i == 3, code[i]);
            cap[i] = last_tdo;
        end
        step(1, 0); step(0, 0);
    endtask

    // From RTI: scan n DR bits with chain returns from the pattern globals
    task automatic shift_dr(input int n, input bit [31:0] din, output bit [31:0] dout);
        dout = '0;
        step(1, 0); step(0, 0); step(0, 0);
        for (int i = 0; i < n; i++) begin
            bs_chain_tdi_i = bs_pat[i];
            debug_tdi_i    = dbg_pat[i];
            mbist_tdi_i    = mb_pat[i];
            step(i == n - 1, din[i]);
            dout[i] = last_tdo;
        end
        step(1, 0); step(0, 0);
    endtask

    function automatic logic [3:0] sels();
        return {extest_sel_o, sample_preload_sel_o, debug_sel_o, mbist_sel_o};
    endfunction

    initial begin
        bit [3:0]  cap;
        bit [31:0] d;
        int        cnt;
        test_logic_reset_i = 1'b1;
        tms_i = 1'b1; tdi_i = 1'b0;
        bs_chain_tdi_i = 1'b0; debug_tdi_i = 1'b0; mbist_tdi_i = 1'b0;
        bs_pat = 32'hA5C3_0F96; dbg_pat = 32'h3C5A_F00F; mb_pat = 32'h6996_C33C;
        @(negedge tclk);
        chk_en = 1'b1;
        @(posedge tclk); #2;

        // Reset held two cycles, then release with TMS=0
        chk("rst_tlr", test_logic_reset_o, 1'b1);
        chk("rst_oe", tdo_oe_o, 1'b0);
        test_logic_reset_i = 1'b0;
        step(0, 0);
        chk("rti_tlr", test_logic_reset_o, 1'b0);
        chk("rti_sels", sels(), 4'b0000);

        // IDCODE read straight after reset
        shift_dr(32, 32'h0, d);
        chk("idcode", d, 32'h1000_0001);

        // IR load 0001 -> captured 0101 on TDO, then SAMPLE_PRELOAD selected
        load_ir(4'b0001, cap);
        chk("ir_cap", cap, 4'b0101);
        chk("sp_sels", sels(), 4'b0100);
        shift_dr(4, 32'h0, d);
        chk("sp_chain", d[3:0], bs_pat[3:0]);

        // TMS=1 x5 from ShDR: one UpdDR pass, land in TLR
        step(1, 0); step(0, 0); step(0, 0);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            step(1, 0);
            if (update_dr_o) cnt++;
        end
        chk("rec_upd_cnt", cnt, 1);
        chk("rec_tlr", test_logic_reset_o, 1'b1);
        chk("rec_sels", sels(), 4'b0000);
        chk("rec_tdo", tdo_o, 1'b0);
        step(0, 0);
        chk("rec_rti_sels", sels(), 4'b0000);

        // DEBUG chain return 1,0,1,1
        load_ir(4'b1000, cap);
        chk("dbg_sels", sels(), 4'b0010);
        dbg_pat = 32'h0000_000D; bs_pat = 32'h0000_0002; mb_pat = 32'h0000_0006;
        shift_dr(4, 32'h0, d);
        chk("dbg_chain", d[3:0], 4'b1101);

        // Unknown opcode 0110 behaves as bypass: TDI 1,0,0,1 -> TDO 0,1,0,0
        load_ir(4'b0110, cap);
        chk("byp_sels", sels(), 4'b0000);
        shift_dr(4, 32'h0000_0009, d);
        chk("byp_data", d[3:0], 4'b0010);

        // MBIST and EXTEST chains
        load_ir(4'b1001, cap);
        chk("mb_sels", sels(), 4'b0001);
        mb_pat = 32'h0000_0003; dbg_pat = 32'h0000_000C; bs_pat = 32'h0000_0005;
        shift_dr(4, 32'h0, d);
        chk("mb_chain", d[3:0], 4'b0011);
        load_ir(4'b0000, cap);
        chk("ext_sels", sels(), 4'b1000);
        bs_pat = 32'h0000_000A;
        shift_dr(4, 32'h0, d);
        chk("ext_chain", d[3:0], 4'b1010);

        // Pause-DR excursion, then UpdDR
        step(1, 0); step(0, 0); step(0, 0); step(0, 0);
        step(1, 0); step(0, 0);
        chk("pause", pause_dr_o, 1'b1);
        step(1, 0); step(0, 0); step(1, 0); step(1, 0);
        chk("upd_dr", update_dr_o, 1'b1);
        step(0, 0);

        // Reset mid DR shift: no UpdDR, straight to TLR
        step(1, 0); step(0, 0); step(0, 1);
        test_logic_reset_i = 1'b1;
        step(1, 1);
        chk("mid_dr_upd", update_dr_o, 1'b0);
        chk("mid_dr_tlr", test_logic_reset_o, 1'b1);
        test_logic_reset_i = 1'b0;
        step(0, 0);

        // Reset mid IR shift: IR stays IDCODE
        step(1, 0); step(1, 0); step(0, 0); step(0, 0); step(0, 1); step(0, 1);
        test_logic_reset_i = 1'b1;
        step(1, 1);
        test_logic_reset_i = 1'b0;
        step(0, 0);
        shift_dr(32, 32'h0, d);
        chk("mid_ir_idcode", d, 32'h1000_0001);

        // Pseudo-random walk, checked cycle by cycle against the model
        for (int i = 0; i < 400; i++) begin
            bs_chain_tdi_i = 1'($urandom_range(0, 1));
            debug_tdi_i    = 1'($urandom_range(0, 1));
            mbist_tdi_i    = 1'($urandom_range(0, 1));
            test_logic_reset_i = ($urandom_range(0, 63) == 0);
            step(($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)));
        end
        test_logic_reset_i = 1'b0;
        step(1, 0);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
